seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE, default 8: consecutive stable cycles required before a digit is sampled (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 20'd1000000: cycles without a capture before `stale` asserts.
REQ-003 The block SHALL have port clk0, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port line, input, 4 bits: one-hot digit select of the scanned display; 4'b0000 means blanking interval.
REQ-006 The block SHALL have port seg7, input, 8 bits: bit7 is the decimal point (ignored); [6:0] are segments g..a, active-high.
REQ-007 The block SHALL have port digits, output, 16 bits: {d3,d2,d1,d0}, where d_i is the BCD value last captured while line[i]=1.
REQ-008 The block SHALL have port blank, output, 4 bits: blank[i]=1 when digit i was last captured as all-segments-off.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when all four digits have been captured since the previous frame.
REQ-010 The block SHALL have ports seg_err and line_err, output, 1 bit each: one-cycle error pulses.
REQ-011 The block SHALL have port stale, output, 1 bit: level, set when the scan has stopped.

Function
REQ-012 The decode table SHALL be 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x27=7, 0x7F=8, 0x6F=9, and 0x00=blank (d_i keeps its value, blank[i]=1); any other pattern is invalid.
REQ-013 The FSM SHALL have exactly three states: WAIT, SETTLE and HOLD.
REQ-014 In WAIT: a one-hot line SHALL latch line and seg7[6:0], clear the settle counter and move to SETTLE; 4'b0000 SHALL stay in WAIT; a multi-hot line SHALL pulse line_err and stay in WAIT.
REQ-015 In SETTLE: if line or seg7[6:0] differs from the latched value, the block SHALL relatch and clear the counter; if the new line is zero it SHALL go to WAIT; if the new line is multi-hot it SHALL pulse line_err and go to WAIT.
REQ-016 In SETTLE, on the cycle the counter equals SETTLE-1 with inputs unchanged, the block SHALL capture and go to HOLD.
REQ-017 Capture of a valid pattern SHALL write d_i and blank[i] on the next clock edge and set mask bit i; an invalid pattern SHALL pulse seg_err and leave d_i, blank[i] and mask bit i unchanged.
REQ-018 In HOLD: line unchanged SHALL keep HOLD (no recapture); a change to a one-hot line SHALL go to SETTLE; a change to zero SHALL go to WAIT; a change to multi-hot SHALL pulse line_err and go to WAIT.
REQ-019 Recapture of a digit already in the mask SHALL overwrite d_i and leave the mask unchanged.
REQ-020 When a capture completes the mask to 4'b1111, frame_valid SHALL pulse on the same edge that updates digits, and the mask SHALL clear on that edge.
REQ-021 The stale counter SHALL clear on every capture (valid or invalid), otherwise increment and saturate.
REQ-022 stale SHALL be 1 while the counter is >= TIMEOUT and return to 0 on the edge following the next capture.
REQ-023 Latency SHALL be SETTLE+1 cycles from the last input change to the digits/frame_valid update.

Reset
REQ-024 rst_n low SHALL immediately force: digits=0, blank=4'hF, frame_valid=0, seg_err=0, line_err=0, stale=0, mask=0, state=WAIT, counters=0.
REQ-025 Deassertion of rst_n SHALL be synchronised to clk0 before the FSM leaves WAIT.
REQ-026 A reset mid-SETTLE SHALL discard the pending capture and SHALL NOT produce a frame_valid.

Structure
REQ-027 The segment code constants and FSM state encodings SHALL live in shared package seg7_pkg, which the display driver reuses.
REQ-028 Combinational pattern-to-BCD decoding SHALL be a sub-module seg7_to_bcd (outputs: value[3:0], is_blank, is_valid).

Verification
REQ-029 Scan line=0001/0010/0100/1000 with seg 0x06/0x5B/0x4F/0x66, each held 1024 cycles -> digits=16'h4321, blank=0, exactly one frame_valid.
REQ-030 line=0100 held for SETTLE-1 cycles, then 0000 -> no capture, d2 unchanged, no frame_valid.
REQ-031 line=0010 with seg 0x7A held 100 cycles -> one seg_err pulse, d1 unchanged, mask bit 1 clear.
REQ-032 line=0011 -> line_err pulse, FSM stays WAIT, no capture.
REQ-033 Scan stopped for TIMEOUT cycles -> stale=1; the next valid capture clears stale on the following edge.
REQ-034 rst_n low for 3 cycles during SETTLE of the 4th digit -> all outputs equal reset values immediately, no frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment code points, scan FSM state encoding and small helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   scan_state_t            : WAIT / SETTLE / HOLD encoding of the scan sampler
//   is_onehot4/is_multihot4 : digit-select classification
//   bcd_to_seg              : forward encoder used by the display driver side
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h27;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    // Exactly one bit set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Two or more bits set (clearing the lowest set bit leaves something).
    function automatic logic is_multihot4(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    // Values above 9 drive an all-off digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment pattern to BCD decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_seg    : segment pattern {g,f,e,d,c,b,a}, active-high
//   value    : decoded digit 0..9 (0 when blank or invalid)
//   is_blank : pattern is all segments off
//   is_valid : pattern is a digit or blank
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] value,
    output logic       is_blank,
    output logic       is_valid
);

    always_comb begin
        value    = 4'd0;
        is_blank = 1'b0;
        is_valid = 1'b1;
        case (i_seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers four BCD digits by sniffing a multiplexed 7-segment display scan.
// Latency: SETTLE+1 cycles from the last line/segment change to the digits/frame_valid update.
// Backpressure: none; the scan is observed every cycle and cannot be stalled.
//
// Ports:
//   clk0        : system clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset; release is synchronised internally
//   line        : one-hot digit select of the scanned display, 4'b0000 = blanking
//   seg7        : {dp, g..a}; dp is ignored
//   digits      : {d3,d2,d1,d0} last captured BCD values
//   blank       : per-digit "last capture was all-off"
//   frame_valid : one-cycle pulse when all four digits were captured since the last frame
//   seg_err     : one-cycle pulse on capture of an undecodable pattern
//   line_err    : one-cycle pulse when line has more than one bit set
//   stale       : level, no capture for TIMEOUT cycles
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int          SETTLE  = 8,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic [3:0]  line,
    input  logic [7:0]  seg7,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        line_err,
    output logic        stale
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [1:0]  r_rst_sync;
    logic        w_run;

    scan_state_t r_state;
    logic [3:0]  r_line;
    logic [6:0]  r_seg;
    logic [7:0]  r_cnt;
    logic        r_cap;
    logic        r_line_err;

    logic [15:0] r_digits;
    logic [3:0]  r_blank;
    logic [3:0]  r_mask;
    logic        r_frame_valid;
    logic        r_seg_err;
    logic [19:0] r_stale_cnt;

    logic [3:0]  w_value;
    logic        w_is_blank;
    logic        w_is_valid;
    logic        w_onehot;
    logic        w_multihot;
    logic        w_line_changed;
    logic        w_seg_changed;
    logic [3:0]  w_mask_next;
    logic        w_unused_dp;

    assign w_unused_dp    = seg7[7];
    assign w_onehot       = is_onehot4(line);
    assign w_multihot     = is_multihot4(line);
    assign w_line_changed = (line != r_line);
    assign w_seg_changed  = (seg7[6:0] != r_seg);
    assign w_mask_next    = r_mask | r_line;

    // Reset assertion is immediate everywhere; release reaches the FSM only
    // after two clean clk0 edges so it never leaves WAIT on a metastable edge.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // The latched pattern is decoded one edge after the capture decision;
    // r_line/r_seg cannot change in between because HOLD ignores segment
    // changes and any relatch on that edge is a non-blocking update.
    seg7_to_bcd u_dec (
        .i_seg    (r_seg),
        .value    (w_value),
        .is_blank (w_is_blank),
        .is_valid (w_is_valid)
    );

    // Scan sampler FSM.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT;
            r_line     <= 4'd0;
            r_seg      <= 7'd0;
            r_cnt      <= 8'd0;
            r_cap      <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_cap      <= 1'b0;
            r_line_err <= 1'b0;
            if (w_run) begin
                case (r_state)
                    ST_WAIT: begin
                        if (w_onehot) begin
                            r_line  <= line;
                            r_seg   <= seg7[6:0];
                            r_cnt   <= 8'd0;
                            r_state <= ST_SETTLE;
                        end else if (w_multihot) begin
                            r_line_err <= 1'b1;
                        end
                    end
                    ST_SETTLE, ST_HOLD: begin
                        // SETTLE restarts on any input change; HOLD only reacts to the
                        // digit select so a held digit is never re-sampled.
                        if (w_line_changed || ((r_state == ST_SETTLE) && w_seg_changed)) begin
                            r_line <= line;
                            r_seg  <= seg7[6:0];
                            r_cnt  <= 8'd0;
                            if (w_onehot) begin
                                r_state <= ST_SETTLE;
                            end else begin
                                r_state    <= ST_WAIT;
                                r_line_err <= w_multihot;
                            end
                        end else if (r_state == ST_SETTLE) begin
                            if (r_cnt == SETTLE_LAST) begin
                                r_cap   <= 1'b1;
                                r_state <= ST_HOLD;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    default: r_state <= ST_WAIT;
                endcase
            end
        end
    end

    // Capture write-back, frame tracking and scan-activity watchdog.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_digits      <= 16'd0;
            r_blank       <= 4'hF;
            r_mask        <= 4'd0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_stale_cnt   <= 20'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            if (r_cap) begin
                // Any capture, good or bad, proves the scan is alive.
                r_stale_cnt <= 20'd0;
                if (w_is_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (r_line[i]) begin
                            r_blank[i] <= w_is_blank;
                            if (!w_is_blank) begin
                                r_digits[i*4 +: 4] <= w_value;
                            end
                        end
                    end
                    if (w_mask_next == 4'hF) begin
                        r_frame_valid <= 1'b1;
                        r_mask        <= 4'd0;
                    end else begin
                        r_mask <= w_mask_next;
                    end
                end else begin
                    r_seg_err <= 1'b1;
                end
            end else if (r_stale_cnt < TIMEOUT) begin
                r_stale_cnt <= r_stale_cnt + 20'd1;
            end
        end
    end

    assign digits      = r_digits;
    assign blank       = r_blank;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign line_err    = r_line_err;
    assign stale       = (r_stale_cnt >= TIMEOUT);

endmodule
